// File: rtl/riscv_defines.sv
// Shared FPU command encodings and widths used by the core and the FPU arbiter.
package riscv_defines;

   localparam int unsigned C_CMD   = 4;
   localparam int unsigned C_RM    = 3;
   localparam int unsigned C_FFLAG = 5;

   localparam logic [C_CMD-1:0] C_FPU_ADD_CMD    = 4'h0;
   localparam logic [C_CMD-1:0] C_FPU_SUB_CMD    = 4'h1;
   localparam logic [C_CMD-1:0] C_FPU_MUL_CMD    = 4'h2;
   localparam logic [C_CMD-1:0] C_FPU_DIV_CMD    = 4'h3;
   localparam logic [C_CMD-1:0] C_FPU_I2F_CMD    = 4'h4;
   localparam logic [C_CMD-1:0] C_FPU_F2I_CMD    = 4'h5;
   localparam logic [C_CMD-1:0] C_FPU_SQRT_CMD   = 4'h6;
   localparam logic [C_CMD-1:0] C_FPU_NOP_CMD    = 4'h7;
   localparam logic [C_CMD-1:0] C_FPU_FMADD_CMD  = 4'h8;
   localparam logic [C_CMD-1:0] C_FPU_FMSUB_CMD  = 4'h9;
   localparam logic [C_CMD-1:0] C_FPU_FNMADD_CMD = 4'hA;
   localparam logic [C_CMD-1:0] C_FPU_FNMSUB_CMD = 4'hB;

   // Upper bound on the number of requesters sharing one FPU
   localparam int unsigned FPU_ARB_MAX_REQ = 8;

   // True for the long-latency iterative commands
   function automatic logic is_divsqrt(input logic [C_CMD-1:0] cmd);
      return (cmd == C_FPU_DIV_CMD) || (cmd == C_FPU_SQRT_CMD);
   endfunction

endpackage

// File: rtl/riscv_fpu_arbiter_if.sv
// Command/response bus between the FPU arbiter (master) and the shared FPU (slave).
interface riscv_fpu_arbiter_if #(
   parameter int unsigned C_OP_WIDTH = 32
) ();
   import riscv_defines::*;

   logic                  fpu_valid_o;
   logic                  fpu_ready_i;
   logic [C_OP_WIDTH-1:0] fpu_op_a_o;
   logic [C_OP_WIDTH-1:0] fpu_op_b_o;
   logic [C_OP_WIDTH-1:0] fpu_op_c_o;
   logic [C_CMD-1:0]      fpu_cmd_o;
   logic [C_RM-1:0]       fpu_rm_o;
   logic                  fpu_rvalid_i;
   logic [C_OP_WIDTH-1:0] fpu_result_i;
   logic [C_FFLAG-1:0]    fpu_fflags_i;

   modport master (
      output fpu_valid_o, fpu_op_a_o, fpu_op_b_o, fpu_op_c_o, fpu_cmd_o, fpu_rm_o,
      input  fpu_ready_i, fpu_rvalid_i, fpu_result_i, fpu_fflags_i
   );

   modport slave (
      input  fpu_valid_o, fpu_op_a_o, fpu_op_b_o, fpu_op_c_o, fpu_cmd_o, fpu_rm_o,
      output fpu_ready_i, fpu_rvalid_i, fpu_result_i, fpu_fflags_i
   );

endinterface

// File: rtl/riscv_fpu_arb_tag_fifo.sv
// In-order tag FIFO holding the requester ID (and optional div/sqrt mark) of each in-flight command.
module riscv_fpu_arb_tag_fifo #(
   parameter int unsigned DEPTH  = 4,
   parameter int unsigned DATA_W = 2
) (
   input  logic                       clk,
   input  logic                       rst,
   input  logic                       push_i,
   input  logic [DATA_W-1:0]          data_i,
   input  logic                       pop_i,
   output logic [DATA_W-1:0]          data_o,
   output logic                       full_o,
   output logic                       empty_o,
   output logic [$clog2(DEPTH):0]     count_o
);

   localparam int unsigned AW    = $clog2(DEPTH);
   localparam int unsigned CNT_W = AW + 1;

   logic [DATA_W-1:0] r_mem [DEPTH];
   logic [AW-1:0]     r_wr_ptr;
   logic [AW-1:0]     r_rd_ptr;
   logic [CNT_W-1:0]  r_count;
   logic              w_push;
   logic              w_pop;

   assign full_o  = (r_count == CNT_W'(DEPTH));
   assign empty_o = (r_count == '0);
   assign count_o = r_count;
   assign data_o  = r_mem[r_rd_ptr];
   assign w_push  = push_i & ~full_o;
   assign w_pop   = pop_i & ~empty_o;

   // Storage write; contents are don't-care until pushed
   always_ff @(posedge clk) begin
      if (w_push) r_mem[r_wr_ptr] <= data_i;
   end

   // Pointers wrap naturally modulo the power-of-two depth
   always_ff @(posedge clk or posedge rst) begin
      if (rst) begin
         r_wr_ptr <= '0;
         r_rd_ptr <= '0;
         r_count  <= '0;
      end else begin
         if (w_push) r_wr_ptr <= r_wr_ptr + AW'(1);
         if (w_pop)  r_rd_ptr <= r_rd_ptr + AW'(1);
         case ({w_push, w_pop})
            2'b10:   r_count <= r_count + CNT_W'(1);
            2'b01:   r_count <= r_count - CNT_W'(1);
            default: r_count <= r_count;
         endcase
      end
   end

endmodule

// File: rtl/riscv_fpu_arbiter.sv
// Round-robin arbiter sharing one FPU between NUM_REQ requesters, with in-order result routing.
// Optional: define RISCV_FPU_ARB_DIVSQRT_BLOCK_EN to hold off new DIV/SQRT while one is in flight.
module riscv_fpu_arbiter
   import riscv_defines::*;
#(
   parameter int unsigned NUM_REQ    = 4,
   parameter int unsigned DEPTH      = 4,
   parameter int unsigned C_OP_WIDTH = 32
) (
   input  logic                          clk,
   input  logic                          rst,
   input  logic [NUM_REQ-1:0]            req_i,
   output logic [NUM_REQ-1:0]            gnt_o,
   input  logic [NUM_REQ*C_OP_WIDTH-1:0] op_a_i,
   input  logic [NUM_REQ*C_OP_WIDTH-1:0] op_b_i,
   input  logic [NUM_REQ*C_OP_WIDTH-1:0] op_c_i,
   input  logic [NUM_REQ*C_CMD-1:0]      cmd_i,
   input  logic [NUM_REQ*C_RM-1:0]       rm_i,
   output logic [NUM_REQ-1:0]            rvalid_o,
   output logic [C_OP_WIDTH-1:0]         result_o,
   output logic [C_FFLAG-1:0]            fflags_o,
   riscv_fpu_arbiter_if.master           fpu,
   output logic                          err_o,
   output logic                          busy_o
);

   localparam int unsigned ID_W  = (NUM_REQ > 1) ? $clog2(NUM_REQ) : 1;
   localparam int unsigned CNT_W = $clog2(DEPTH) + 1;
`ifdef RISCV_FPU_ARB_DIVSQRT_BLOCK_EN
   localparam int unsigned TAG_W = ID_W + 1;
`else
   localparam int unsigned TAG_W = ID_W;
`endif

   logic [ID_W-1:0]       r_ptr;
   logic [NUM_REQ-1:0]    r_rvalid;
   logic [C_OP_WIDTH-1:0] r_result;
   logic [C_FFLAG-1:0]    r_fflags;
   logic                  r_err;

   logic [NUM_REQ-1:0]    w_req_eff;
   logic [ID_W-1:0]       w_winner;
   logic [ID_W-1:0]       w_hi;
   logic [ID_W-1:0]       w_lo;
   logic                  w_hi_found;
   logic                  w_lo_found;
   logic                  w_issue_en;
   logic                  w_hs;
   logic                  w_pop;
   logic                  w_full;
   logic                  w_empty;
   logic [CNT_W-1:0]      w_count;
   logic [TAG_W-1:0]      w_push_tag;
   logic [TAG_W-1:0]      w_head_tag;
   logic [ID_W-1:0]       w_head_id;
   logic [C_CMD-1:0]      w_win_cmd;

`ifdef RISCV_FPU_ARB_DIVSQRT_BLOCK_EN
   logic r_div_busy;
   logic w_win_divsqrt;

   // Mask requesters presenting DIV/SQRT while the divider is occupied
   always_comb begin
      w_req_eff = req_i;
      for (int r = 0; r < NUM_REQ; r++) begin
         if (r_div_busy && is_divsqrt(cmd_i[r*C_CMD +: C_CMD])) w_req_eff[r] = 1'b0;
      end
   end

   assign w_win_divsqrt = is_divsqrt(w_win_cmd);
   assign w_push_tag    = {w_win_divsqrt, w_winner};

   // Divider occupancy: set on DIV/SQRT issue, cleared by its tagged response
   always_ff @(posedge clk or posedge rst) begin
      if (rst)                             r_div_busy <= 1'b0;
      else if (w_hs && w_win_divsqrt)      r_div_busy <= 1'b1;
      else if (w_pop && w_head_tag[ID_W])  r_div_busy <= 1'b0;
   end
`else
   assign w_req_eff  = req_i;
   assign w_push_tag = w_winner;
`endif

   // Round-robin search: lowest request at/after the pointer, else lowest overall
   always_comb begin
      w_hi       = '0;
      w_lo       = '0;
      w_hi_found = 1'b0;
      w_lo_found = 1'b0;
      for (int i = NUM_REQ - 1; i >= 0; i--) begin
         if (w_req_eff[i]) begin
            w_lo       = ID_W'(i);
            w_lo_found = 1'b1;
            if (i >= int'(r_ptr)) begin
               w_hi       = ID_W'(i);
               w_hi_found = 1'b1;
            end
         end
      end
      w_winner = w_hi_found ? w_hi : w_lo;
   end

   assign w_issue_en = w_lo_found & ~w_full;
   assign w_hs       = w_issue_en & fpu.fpu_ready_i;
   assign w_pop      = fpu.fpu_rvalid_i & ~w_empty;
   assign w_head_id  = w_head_tag[ID_W-1:0];
   assign w_win_cmd  = cmd_i[32'(w_winner)*C_CMD +: C_CMD];

   assign fpu.fpu_valid_o = w_issue_en;
   assign fpu.fpu_op_a_o  = op_a_i[32'(w_winner)*C_OP_WIDTH +: C_OP_WIDTH];
   assign fpu.fpu_op_b_o  = op_b_i[32'(w_winner)*C_OP_WIDTH +: C_OP_WIDTH];
   assign fpu.fpu_op_c_o  = op_c_i[32'(w_winner)*C_OP_WIDTH +: C_OP_WIDTH];
   assign fpu.fpu_cmd_o   = w_win_cmd;
   assign fpu.fpu_rm_o    = rm_i[32'(w_winner)*C_RM +: C_RM];

   // One-hot grant on the handshake
   always_comb begin
      gnt_o = '0;
      if (w_hs) gnt_o[w_winner] = 1'b1;
   end

   // Pointer moves one past the granted requester
   always_ff @(posedge clk or posedge rst) begin
      if (rst) begin
         r_ptr <= '0;
      end else if (w_hs) begin
         r_ptr <= (w_winner == ID_W'(NUM_REQ - 1)) ? '0 : w_winner + ID_W'(1);
      end
   end

   riscv_fpu_arb_tag_fifo #(
      .DEPTH  (DEPTH),
      .DATA_W (TAG_W)
   ) u_tag_fifo (
      .clk     (clk),
      .rst     (rst),
      .push_i  (w_hs),
      .data_i  (w_push_tag),
      .pop_i   (w_pop),
      .data_o  (w_head_tag),
      .full_o  (w_full),
      .empty_o (w_empty),
      .count_o (w_count)
   );

   // Response routing to the oldest in-flight requester; orphan responses raise a sticky error
   always_ff @(posedge clk or posedge rst) begin
      if (rst) begin
         r_rvalid <= '0;
         r_result <= '0;
         r_fflags <= '0;
         r_err    <= 1'b0;
      end else begin
         r_rvalid <= '0;
         if (w_pop) begin
            r_rvalid[w_head_id] <= 1'b1;
            r_result            <= fpu.fpu_result_i;
            r_fflags            <= fpu.fpu_fflags_i;
         end
         if (fpu.fpu_rvalid_i && w_empty) r_err <= 1'b1;
      end
   end

   assign rvalid_o = r_rvalid;
   assign result_o = r_result;
   assign fflags_o = r_fflags;
   assign err_o    = r_err;
   assign busy_o   = (w_count != '0);

endmodule
